dcache_ctrl: RTL

- Blocking controller for the direct-mapped, 64-set data-cache line store `cache_ram`.
- Write-through, no-write-allocate policy.
- Accepts one CPU load/store at a time and performs tag lookup using the 1-cycle RAM read latency.
- Refills misses over a 4-beat memory read burst, forwards stores to memory, and provides a whole-cache invalidate sweep.
- Sits between the LSU and the memory-bus bridge.

---
 rtl/dcache_pkg.sv | 39 +++
 rtl/dcache_refill_buf.sv | 35 +++
 rtl/dcache_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and field layout for the blocking data-cache controller.
// A RAM line is {valid, tag, 4 x 32-bit words}, word 0 in the low bits.
package dcache_pkg;
  localparam int INDEX_W   = 6;
  localparam int TAG_W     = 22;
  localparam int OFFSET_W  = 2;
  localparam int LINE_W    = 151;
  localparam int VALID_BIT = 150;
  localparam int TAG_HI    = 149;
  localparam int TAG_LO    = 128;
  localparam int DATA_HI   = 127;
  localparam int DATA_LO   = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_REQ, S_REFILL, S_FILL, S_WR, S_INV
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] r;
    r = word;
    for (int b = 0; b < 4; b++)
      if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] word_sel(input logic [DATA_HI:DATA_LO] data,
                                           input logic [OFFSET_W-1:0] off);
    return data[{off, 5'b0} +: 32];
  endfunction
endpackage

// File: rtl/dcache_refill_buf.sv
// Collects the four refill beats of a line; line_o already includes the
// beat arriving this cycle so the final write needs no extra cycle.
module dcache_refill_buf (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         beat_vld_i,
  input  logic [31:0]  beat_data_i,
  output logic [127:0] line_o,
  output logic         done_o
);
  logic [3:0][31:0] line_q;
  logic [3:0][31:0] line_nxt;
  logic [1:0]       cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (beat_vld_i) begin
      line_q[cnt_q] <= beat_data_i;
      cnt_q         <= cnt_q + 2'd1;
    end
  end

  always_comb begin
    line_nxt = line_q;
    if (beat_vld_i) line_nxt[cnt_q] = beat_data_i;
  end

  assign line_o = line_nxt;
  assign done_o = beat_vld_i && (cnt_q == 2'd3);
endmodule

// File: rtl/dcache_ctrl.sv
// Blocking write-through / no-write-allocate controller for a direct-mapped
// 64-set cache: lookup, 4-beat refill, store forwarding and invalidate sweep.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [3:0]          req_wstrb,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  input  logic                inv_req,
  output logic                inv_done,
  output logic                ram_we,
  output logic [INDEX_W-1:0]  ram_w_index,
  output logic [INDEX_W-1:0]  ram_r_index,
  output logic [LINE_W-1:0]   ram_data_in,
  input  logic [LINE_W-1:0]   ram_data_out,
  output logic                mem_rd_req,
  output logic [31:0]         mem_rd_addr,
  input  logic                mem_rd_ready,
  input  logic                mem_rd_valid,
  input  logic [31:0]         mem_rd_data,
  output logic                mem_wr_req,
  output logic [31:0]         mem_wr_addr,
  output logic [31:0]         mem_wr_data,
  output logic [3:0]          mem_wr_strb,
  input  logic                mem_wr_ready
);
  state_e              state_q;
  req_t                req_q;
  logic [INDEX_W-1:0]  sweep_q;
  logic                out_en_q;
  logic                resp_valid_q, inv_done_q, ram_we_q, mem_rd_req_q, mem_wr_req_q;
  logic [31:0]         resp_rdata_q;
  logic [INDEX_W-1:0]  ram_w_index_q;
  logic [LINE_W-1:0]   ram_data_in_q;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic [OFFSET_W-1:0] off;
  logic                hit, beat_vld, fill_done;
  logic [127:0]        fill_line;
  logic [LINE_W-1:0]   st_line;

  assign idx = req_q.addr[9:4];
  assign tag = req_q.addr[31:10];
  assign off = req_q.addr[3:2];
  assign hit = ram_data_out[VALID_BIT] && (ram_data_out[TAG_HI:TAG_LO] == tag);

  always_comb begin
    st_line = ram_data_out;
    st_line[{off, 5'b0} +: 32] = byte_merge(word_sel(ram_data_out[DATA_HI:DATA_LO], off),
                                            req_q.wdata, req_q.wstrb);
  end

  assign beat_vld = (state_q == S_REFILL) && mem_rd_valid;

  dcache_refill_buf u_rbuf (
    .clk_i       (clk),
    .rst_ni      (rst),
    .clr_i       (state_q != S_REFILL),
    .beat_vld_i  (beat_vld),
    .beat_data_i (mem_rd_data),
    .line_o      (fill_line),
    .done_o      (fill_done)
  );

  // out_en_q keeps req_ready low while reset is held and for the first cycle after.
  assign req_ready   = out_en_q && (state_q == S_IDLE) && !inv_req;
  assign ram_r_index = (state_q == S_IDLE) ? req_addr[9:4] : idx;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign inv_done    = inv_done_q;
  assign ram_we      = ram_we_q;
  assign ram_w_index = ram_w_index_q;
  assign ram_data_in = ram_data_in_q;
  assign mem_rd_req  = mem_rd_req_q;
  assign mem_rd_addr = {tag, idx, 4'b0};
  assign mem_wr_req  = mem_wr_req_q;
  assign mem_wr_addr = req_q.addr;
  assign mem_wr_data = req_q.wdata;
  assign mem_wr_strb = req_q.wstrb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      req_q         <= '0;
      sweep_q       <= '0;
      out_en_q      <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      inv_done_q    <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_w_index_q <= '0;
      ram_data_in_q <= '0;
      mem_rd_req_q  <= 1'b0;
      mem_wr_req_q  <= 1'b0;
    end else begin
      out_en_q     <= 1'b1;
      resp_valid_q <= 1'b0;
      inv_done_q   <= 1'b0;
      ram_we_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (inv_req) begin
            state_q       <= S_INV;
            sweep_q       <= '0;
            ram_we_q      <= 1'b1;
            ram_w_index_q <= '0;
            ram_data_in_q <= '0;
          end else if (req_valid && req_ready) begin
            req_q   <= '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (!req_q.we) begin
            if (hit) begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= word_sel(ram_data_out[DATA_HI:DATA_LO], off);
              state_q      <= S_IDLE;
            end else begin
              mem_rd_req_q <= 1'b1;
              state_q      <= S_MISS_REQ;
            end
          end else begin
            // No-write-allocate: only a hit touches the line store.
            if (hit) begin
              ram_we_q      <= 1'b1;
              ram_w_index_q <= idx;
              ram_data_in_q <= st_line;
            end
            mem_wr_req_q <= 1'b1;
            state_q      <= S_WR;
          end
        end
        S_MISS_REQ: begin
          if (mem_rd_ready) begin
            mem_rd_req_q <= 1'b0;
            state_q      <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (fill_done) begin
            ram_we_q      <= 1'b1;
            ram_w_index_q <= idx;
            ram_data_in_q <= {1'b1, tag, fill_line};
            resp_valid_q  <= 1'b1;
            resp_rdata_q  <= word_sel(fill_line, off);
            state_q       <= S_FILL;
          end
        end
        S_FILL: state_q <= S_IDLE;
        S_WR: begin
          if (mem_wr_ready) begin
            mem_wr_req_q <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= S_IDLE;
          end
        end
        S_INV: begin
          if (sweep_q == 6'd63) begin
            inv_done_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            sweep_q       <= sweep_q + 6'd1;
            ram_we_q      <= 1'b1;
            ram_w_index_q <= sweep_q + 6'd1;
            ram_data_in_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule
